// File: rtl/data_mem_master_pkg.sv
// rtl/data_mem_master_pkg.sv - FSM encoding and timeout counter sizing for data_mem_master
package data_mem_master_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int DEFAULT_TIMEOUT = 15;

  function automatic int cntWidth(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/data_mem_master_req_skid_buf.sv
// rtl/data_mem_master_req_skid_buf.sv - single-entry pending-request slot {write, addr, wdata}
module data_mem_master_req_skid_buf #(
  parameter int width  = 8,
  parameter int length = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inValid,
  output logic              inReady,
  input  logic              inWrite,
  input  logic [length-1:0] inAddr,
  input  logic [width-1:0]  inData,
  output logic              outValid,
  input  logic              outReady,
  output logic              outWrite,
  output logic [length-1:0] outAddr,
  output logic [width-1:0]  outData
);

  // Holds inReady low through reset and until the first edge after release.
  logic live;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      live     <= 1'b0;
      outValid <= 1'b0;
      outWrite <= 1'b0;
      outAddr  <= '0;
      outData  <= '0;
    end else begin
      live <= 1'b1;
      if (inValid && inReady) begin
        outValid <= 1'b1;
        outWrite <= inWrite;
        outAddr  <= inAddr;
        outData  <= inData;
      end else if (outReady && outValid) begin
        outValid <= 1'b0;
      end
    end
  end

  assign inReady = live && !outValid;

endmodule

// File: rtl/data_mem_master.sv
// rtl/data_mem_master.sv - data-RAM initiator: core load/store requests to RAM strobes, with pending slot and read timeout
module data_mem_master
  import data_mem_master_pkg::*;
#(
  parameter int width   = 8,
  parameter int length  = 8,
  parameter int timeout = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [length-1:0] req_addr,
  input  logic [width-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [width-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              ram_writeEnable,
  output logic              ram_readEnable,
  output logic [length-1:0] ram_addr,
  output logic [length-1:0] ram_readAddr,
  output logic [width-1:0]  ram_writeData,
  input  logic              ram_dataReady,
  input  logic [width-1:0]  ram_readData
);

  localparam int cntW = cntWidth(timeout);
  localparam logic [cntW-1:0] lastWait = cntW'(timeout - 1);

  logic [1:0]        state;
  logic [cntW-1:0]   waitCnt;
  logic              slotValid;
  logic              slotWrite;
  logic [length-1:0] slotAddr;
  logic [width-1:0]  slotData;

  logic              accept;
  logic              push;
  logic              freeForOp;
  logic              startSlot;
  logic              startOp;
  logic              opWrite;
  logic [length-1:0] opAddr;
  logic [width-1:0]  opData;

  assign accept    = req_valid && req_ready;
  assign push      = accept && (state != S_IDLE);
  assign freeForOp = (state == S_IDLE) || (state == S_WRITE) || (state == S_GAP);
  // The slot always wins; a new request only starts directly from an empty IDLE.
  assign startSlot = freeForOp && slotValid;
  assign startOp   = startSlot || ((state == S_IDLE) && accept);
  assign opWrite   = startSlot ? slotWrite : req_write;
  assign opAddr    = startSlot ? slotAddr  : req_addr;
  assign opData    = startSlot ? slotData  : req_wdata;

  data_mem_master_req_skid_buf #(
    .width  (width),
    .length (length)
  ) slotBuf (
    .clk      (clk),
    .clr      (clr),
    .inValid  (push),
    .inReady  (req_ready),
    .inWrite  (req_write),
    .inAddr   (req_addr),
    .inData   (req_wdata),
    .outValid (slotValid),
    .outReady (startSlot),
    .outWrite (slotWrite),
    .outAddr  (slotAddr),
    .outData  (slotData)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state           <= S_IDLE;
      waitCnt         <= '0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      ram_writeEnable <= 1'b0;
      ram_readEnable  <= 1'b0;
      ram_addr        <= '0;
      ram_readAddr    <= '0;
      ram_writeData   <= '0;
    end else begin
      rsp_valid       <= 1'b0;
      rsp_err         <= 1'b0;
      ram_writeEnable <= 1'b0;
      case (state)
        S_READ: begin
          if (ram_dataReady) begin
            rsp_rdata      <= ram_readData;
            rsp_valid      <= 1'b1;
            ram_readEnable <= 1'b0;
            state          <= S_GAP;
          end else if (waitCnt == lastWait) begin
            rsp_valid      <= 1'b1;
            rsp_err        <= 1'b1;
            ram_readEnable <= 1'b0;
            waitCnt        <= '0;
            state          <= S_GAP;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: begin
          if (state == S_WRITE) begin
            rsp_valid <= 1'b1;
          end
          if (startOp) begin
            waitCnt <= '0;
            if (opWrite) begin
              state           <= S_WRITE;
              ram_writeEnable <= 1'b1;
              ram_addr        <= opAddr;
              ram_writeData   <= opData;
            end else begin
              state          <= S_READ;
              ram_readEnable <= 1'b1;
              ram_readAddr   <= opAddr;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_master.sv
// tb/tb_data_mem_master.sv - self-checking bench for data_mem_master with a negedge RAM model
module tb_data_mem_master;

  logic       clk;
  logic       clr;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       ram_writeEnable;
  logic       ram_readEnable;
  logic [7:0] ram_addr;
  logic [7:0] ram_readAddr;
  logic [7:0] ram_writeData;
  logic       ram_dataReady;
  logic [7:0] ram_readData;

  data_mem_master #(.width(8), .length(8), .timeout(15)) dut (
    .clk             (clk),
    .clr             (clr),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .ram_writeEnable (ram_writeEnable),
    .ram_readEnable  (ram_readEnable),
    .ram_addr        (ram_addr),
    .ram_readAddr    (ram_readAddr),
    .ram_writeData   (ram_writeData),
    .ram_dataReady   (ram_dataReady),
    .ram_readData    (ram_readData)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  function automatic logic [7:0] initVal(input int i);
    return 8'(i) ^ 8'hC3;
  endfunction

  // RAM model: samples strobes on the falling edge; ramHang keeps dataReady low.
  logic [7:0] ramMem [256];
  bit         ramInitDone;
  bit         ramHang;

  always @(negedge clk) begin
    if (!ramInitDone) begin
      for (int i = 0; i < 256; i++) ramMem[i] <= initVal(i);
      ramInitDone <= 1'b1;
    end else if (ram_writeEnable) begin
      ramMem[ram_addr] <= ram_writeData;
    end
    if (ram_readEnable && !ramHang) begin
      ram_dataReady <= 1'b1;
      ram_readData  <= ramMem[ram_readAddr];
    end else begin
      ram_dataReady <= 1'b0;
    end
  end

  int nTests;
  int nFail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] expRdata;
  } vec_t;

  typedef struct {
    logic       isRead;
    logic [7:0] data;
  } exp_t;

  vec_t       vecs [10];
  exp_t       expQ [$];
  exp_t       e;
  logic [7:0] refMem [256];
  int         reCycles;
  int         sawRsp;
  int         sawWe;
  bit         fired;

  task automatic doOp(input int idx, input vec_t v);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    check($sformatf("vec%0d_ready", idx), req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.wr) begin
      check($sformatf("vec%0d_strobes", idx), {ram_writeEnable, ram_readEnable}, 2'b10);
      check($sformatf("vec%0d_waddr", idx), ram_addr, v.addr);
      check($sformatf("vec%0d_wdata", idx), ram_writeData, v.wdata);
    end else begin
      check($sformatf("vec%0d_strobes", idx), {ram_writeEnable, ram_readEnable}, 2'b01);
      check($sformatf("vec%0d_raddr", idx), ram_readAddr, v.addr);
    end
    @(posedge clk); #1;
    check($sformatf("vec%0d_rsp", idx), {rsp_valid, rsp_err}, 2'b10);
    check($sformatf("vec%0d_strobes_off", idx), {ram_writeEnable, ram_readEnable}, 2'b00);
    if (!v.wr) check($sformatf("vec%0d_rdata", idx), rsp_rdata, v.expRdata);
    @(posedge clk); #1;
    check($sformatf("vec%0d_rsp_end", idx), rsp_valid, 0);
  endtask

  initial begin
    nTests    = 0;
    nFail     = 0;
    ramHang   = 1'b0;
    clr       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    for (int i = 0; i < 256; i++) refMem[i] = initVal(i);

    vecs[0] = '{1'b1, 8'h10, 8'h5A, 8'h00};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[2] = '{1'b1, 8'hFF, 8'hA5, 8'h00};
    vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 8'h00, 8'h01, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h01};
    vecs[6] = '{1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[7] = '{1'b0, 8'h55, 8'h00, 8'h96};
    vecs[8] = '{1'b1, 8'h20, 8'h11, 8'h00};
    vecs[9] = '{1'b1, 8'h21, 8'h22, 8'h00};

    // Reset: asserted mid-cycle, released on a falling edge.
    #2 clr = 1'b1;
    #28;
    check("reset_outputs",
          {req_ready, rsp_valid, rsp_rdata, rsp_err, ram_writeEnable, ram_readEnable,
           ram_addr, ram_readAddr, ram_writeData}, 64'd0);
    #10 clr = 1'b0;
    #10;
    check("reset_ready_before_edge", req_ready, 0);
    @(posedge clk); #1;
    check("reset_ready_after_edge", req_ready, 1);

    for (int i = 0; i < 10; i++) doOp(i, vecs[i]);

    // Back-to-back loads with a third request held off by the full slot.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h20;
    @(posedge clk); #1;
    check("b2b_re0", {ram_writeEnable, ram_readEnable}, 2'b01);
    check("b2b_raddr0", ram_readAddr, 8'h20);
    check("b2b_ready_c1", req_ready, 1);
    req_addr = 8'h21;
    @(posedge clk); #1;
    check("b2b_rsp0", {rsp_valid, rsp_err}, 2'b10);
    check("b2b_rdata0", rsp_rdata, 8'h11);
    check("b2b_gap0", {ram_writeEnable, ram_readEnable}, 2'b00);
    check("b2b_ready_full", req_ready, 0);
    req_write = 1'b1; req_addr = 8'h22; req_wdata = 8'h33;
    @(posedge clk); #1;
    check("b2b_re1", {ram_writeEnable, ram_readEnable}, 2'b01);
    check("b2b_raddr1", ram_readAddr, 8'h21);
    check("b2b_ready_c3", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_rsp1", {rsp_valid, rsp_err}, 2'b10);
    check("b2b_rdata1", rsp_rdata, 8'h22);
    check("b2b_gap1", {ram_writeEnable, ram_readEnable}, 2'b00);
    check("b2b_ready_full2", req_ready, 0);
    @(posedge clk); #1;
    check("b2b_we2", {ram_writeEnable, ram_readEnable}, 2'b10);
    check("b2b_waddr2", {ram_addr, ram_writeData}, 16'h2233);
    @(posedge clk); #1;
    check("b2b_rsp2", {rsp_valid, rsp_err, ram_writeEnable}, 3'b100);
    @(posedge clk); #1;

    // Read timeout with a RAM that never answers.
    ramHang = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reCycles = 0;
    for (int i = 0; i < 40 && ram_readEnable; i++) begin
      reCycles++;
      @(posedge clk); #1;
    end
    check("timeout_re_cycles", reCycles, 15);
    check("timeout_rsp", {rsp_valid, rsp_err}, 2'b11);
    check("timeout_rdata_held", rsp_rdata, 8'h22);
    check("timeout_gap", {ram_writeEnable, ram_readEnable}, 2'b00);
    ramHang = 1'b0;
    @(posedge clk); #1;
    check("timeout_rsp_end", rsp_valid, 0);

    // clr while a read hangs and a store waits in the slot.
    ramHang = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 8'h41; req_wdata = 8'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("clr_pre_re", ram_readEnable, 1);
    check("clr_pre_slot_full", req_ready, 0);
    #5 clr = 1'b1;
    #1;
    check("clr_strobes", {ram_writeEnable, ram_readEnable, rsp_valid}, 3'b000);
    #10 clr = 1'b0;
    ramHang = 1'b0;
    sawRsp = 0;
    sawWe  = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) sawRsp++;
      if (ram_writeEnable) sawWe++;
    end
    check("clr_no_rsp", sawRsp, 0);
    check("clr_no_write", sawWe, 0);
    check("clr_mem_untouched", ramMem[8'h41], refMem[8'h41]);

    // Randomised traffic against an in-order reference model.
    fired = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (fired) begin
        if (req_write) begin
          refMem[req_addr] = req_wdata;
          expQ.push_back('{1'b0, 8'h00});
        end else begin
          expQ.push_back('{1'b1, refMem[req_addr]});
        end
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        if (expQ.size() == 0) begin
          check("rnd_extra_rsp", rsp_valid, 0);
        end else begin
          e = expQ.pop_front();
          check("rnd_rsp_err", rsp_err, 0);
          if (e.isRead) check("rnd_rdata", rsp_rdata, e.data);
        end
      end
      check("rnd_strobe_excl", ram_writeEnable & ram_readEnable, 0);
      if (c < 300 && !req_valid && $urandom_range(0, 2) != 0) begin
        req_valid = 1'b1;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 8'h80 | 8'($urandom_range(0, 7));
        req_wdata = 8'($urandom);
      end
      fired = req_valid && req_ready;
    end
    check("rnd_all_responses", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
